punc_mem_responder: RTL

//  Memory-side responder for the PUnC LC3 control/datapath memory interface: accepts one

---
 rtl/punc_pkg.sv | 19 +
 rtl/punc_mem_array.sv | 27 ++
 rtl/punc_mem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/punc_pkg.sv
// Shared types and constants for the PUnC memory responder.
package punc_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    // Responder FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_WAIT = 2'd1,
        RS_RESP = 2'd2
    } rs_state_t;

    // Wait-counter preload: the counter runs from LATENCY-1 down to 0 inside WAIT
    function automatic logic [CNT_W-1:0] wait_preload(input int latency);
        return (latency > 0) ? CNT_W'(latency - 1) : '0;
    endfunction

endpackage

// File: rtl/punc_mem_array.sv
// Single-port RAM: synchronous write, registered read (old data on read-during-write).
module punc_mem_array
    import punc_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    logic [WORD_W-1:0] r_rdata;

    // Write when enabled; the addressed word is read into r_rdata every cycle
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/punc_mem_responder.sv
// Memory-side responder for the PUnC core: one request at a time, programmable
// wait states, one-cycle response pulse, plus a preload port for the loader.
module punc_mem_responder
    import punc_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    input  logic              load_mode,
    input  logic              ld_valid,
    input  logic [WORD_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data,
    output logic              ld_ready,
    output logic [WORD_W-1:0] ld_count,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = wait_preload(LATENCY);

    rs_state_t         r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_ld_count;

    logic              w_idle;
    logic              w_req_fire;
    logic              w_ld_fire;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [WORD_W-1:0] w_ram_wdata;
    logic [WORD_W-1:0] w_ram_rdata;
    logic              w_unused_addr_bits;

    assign w_idle     = (r_state == RS_IDLE);
    assign req_ready  = w_idle & ~load_mode;
    assign ld_ready   = w_idle & load_mode;
    assign w_req_fire = req_valid & req_ready;
    assign w_ld_fire  = ld_valid & ld_ready;

    // Addresses alias into the RAM; the discarded upper bits are deliberately unused
    assign w_unused_addr_bits = ^{req_addr[WORD_W-1:ADDR_W], ld_addr[WORD_W-1:ADDR_W]};

    // RAM port mux: loader or incoming request address in IDLE, latched request afterwards.
    // The read issued in the cycle before RESP lands in w_ram_rdata during RESP.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = r_addr;
        w_ram_wdata = r_wdata;
        case (r_state)
            RS_IDLE: begin
                if (load_mode) begin
                    w_ram_we    = w_ld_fire;
                    w_ram_addr  = ld_addr[ADDR_W-1:0];
                    w_ram_wdata = ld_data;
                end else begin
                    w_ram_addr  = req_addr[ADDR_W-1:0];
                end
            end
            RS_RESP: w_ram_we = r_we;
            default: ;
        endcase
        // A reset edge must never commit a pending write
        if (rst) begin
            w_ram_we = 1'b0;
        end
    end

    punc_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Transaction FSM: IDLE -> WAIT (LATENCY cycles) -> RESP -> IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RS_IDLE;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                RS_IDLE: begin
                    if (w_req_fire) begin
                        r_wait_cnt <= WAIT_LOAD;
                        r_state    <= (LATENCY > 0) ? RS_WAIT : RS_RESP;
                    end
                end
                RS_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= RS_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                RS_RESP: r_state <= RS_IDLE;
                default: r_state <= RS_IDLE;
            endcase
        end
    end

    // Capture request fields on acceptance so the core may change them afterwards
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_we    <= req_we;
            r_addr  <= req_addr[ADDR_W-1:0];
            r_wdata <= req_wdata;
        end
    end

    // Count accepted loader writes, wrapping naturally at 2**16
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_count <= '0;
        end else if (w_ld_fire) begin
            r_ld_count <= r_ld_count + 1'b1;
        end
    end

    assign rsp_valid = (r_state == RS_RESP);
    assign rsp_rdata = (rsp_valid && !r_we) ? w_ram_rdata : '0;
    assign ld_count  = r_ld_count;
    assign busy      = ~w_idle;

endmodule
